// File: rtl/sram_rr_arbiter.sv
// Round-robin SRAM command arbiter for write and read channels. It tracks reads in
// flight with an in-order tag queue and routes returned data to per-channel FWFT buffers.
module sram_rr_arbiter #(
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 2,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int MASK_W     = 4,
  parameter int MAX_OUTST  = 8,
  parameter int RESP_DEPTH = 4
) (
  input  logic                       sram_clock,
  input  logic                       reset,
  input  logic [NUM_WR-1:0]          wr_valid,
  output logic [NUM_WR-1:0]          wr_ready,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_WR*MASK_W-1:0]   wr_mask,
  input  logic [NUM_RD-1:0]          rd_req_valid,
  output logic [NUM_RD-1:0]          rd_req_ready,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_req_addr,
  output logic [NUM_RD-1:0]          rd_resp_valid,
  input  logic [NUM_RD-1:0]          rd_resp_ready,
  output logic [NUM_RD*DATA_W-1:0]   rd_resp_data,
  output logic                       sram_addr_valid,
  input  logic                       sram_ready,
  output logic [ADDR_W-1:0]          sram_addr,
  output logic [DATA_W-1:0]          sram_data_in,
  output logic [MASK_W-1:0]          sram_write_mask,
  input  logic [DATA_W-1:0]          sram_data_out,
  input  logic                       sram_data_out_valid,
  output logic                       orphan_err
);

  localparam int NREQ  = NUM_WR + NUM_RD;
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CH_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int TQ_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int TC_W  = $clog2(MAX_OUTST + 1);
  localparam int RB_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int RC_W  = $clog2(RESP_DEPTH + 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic              cmd_vld_p0;
  logic              cmd_rd_p0;
  logic [CH_W-1:0]   cmd_ch_p0;
  logic [ADDR_W-1:0] cmd_addr_p0;
  logic [DATA_W-1:0] cmd_data_p0;
  logic [MASK_W-1:0] cmd_mask_p0;

  logic [CH_W-1:0]   tq_mem [MAX_OUTST];
  logic [TQ_W-1:0]   tq_head, tq_tail;
  logic [TC_W-1:0]   tq_cnt;
  logic [RC_W-1:0]   outst [NUM_RD];
  logic [RC_W-1:0]   occ [NUM_RD];
  logic [DATA_W-1:0] rb_mem [NUM_RD][RESP_DEPTH];
  logic [RB_W-1:0]   rb_head [NUM_RD];
  logic [RB_W-1:0]   rb_tail [NUM_RD];
  logic              orphan_q;

  logic              load, issue, ret_ok, rd_pend, found;
  logic [CH_W-1:0]   ret_ch;
  logic [NREQ-1:0]   elig;
  logic [PTR_W-1:0]  scan_idx, win;
  logic [NUM_RD-1:0] rb_push, rb_pop;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_data;
  logic [MASK_W-1:0] nxt_mask;
  logic              nxt_rd;
  logic [CH_W-1:0]   nxt_ch;
  int                rsv_tags;

  assign load     = !reset && (!cmd_vld_p0 || sram_ready);
  assign issue    = cmd_vld_p0 && sram_ready && cmd_rd_p0;
  assign ret_ok   = sram_data_out_valid && (tq_cnt != '0);
  assign ret_ch   = tq_mem[tq_head];
  assign rd_pend  = cmd_vld_p0 && cmd_rd_p0;
  // A read sitting in the command register already holds its tag and credit.
  assign rsv_tags = int'(tq_cnt) + (rd_pend ? 1 : 0);

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_WR; i++) elig[i] = wr_valid[i];
    for (int j = 0; j < NUM_RD; j++) begin
      elig[NUM_WR+j] = rd_req_valid[j] && (rsv_tags < MAX_OUTST) &&
                       ((int'(outst[j]) + int'(occ[j]) +
                         ((rd_pend && int'(cmd_ch_p0) == j) ? 1 : 0)) < RESP_DEPTH);
    end
  end

  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % NREQ);
      if (!found && elig[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  always_comb begin
    wr_ready     = '0;
    rd_req_ready = '0;
    nxt_addr     = '0;
    nxt_data     = '0;
    nxt_mask     = '0;
    nxt_rd       = 1'b0;
    nxt_ch       = '0;
    if (found) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (int'(win) == i) begin
          wr_ready[i] = load;
          nxt_addr    = wr_addr[i*ADDR_W +: ADDR_W];
          nxt_data    = wr_data[i*DATA_W +: DATA_W];
          nxt_mask    = wr_mask[i*MASK_W +: MASK_W];
        end
      end
      for (int j = 0; j < NUM_RD; j++) begin
        if (int'(win) == NUM_WR + j) begin
          rd_req_ready[j] = load;
          nxt_addr        = rd_req_addr[j*ADDR_W +: ADDR_W];
          nxt_rd          = 1'b1;
          nxt_ch          = CH_W'(j);
        end
      end
    end
  end

  always_comb begin
    rd_resp_valid = '0;
    rd_resp_data  = '0;
    rb_push       = '0;
    rb_pop        = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rd_resp_valid[j] = (occ[j] != '0);
      rb_push[j]       = ret_ok && (int'(ret_ch) == j);
      rb_pop[j]        = (occ[j] != '0) && rd_resp_ready[j];
      if (occ[j] != '0) rd_resp_data[j*DATA_W +: DATA_W] = rb_mem[j][rb_head[j]];
    end
  end

  // Stage p0: command register, tag queue and credit bookkeeping
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      cmd_vld_p0  <= 1'b0;
      cmd_rd_p0   <= 1'b0;
      cmd_ch_p0   <= '0;
      cmd_addr_p0 <= '0;
      cmd_data_p0 <= '0;
      cmd_mask_p0 <= '0;
      rr_ptr      <= '0;
      tq_head     <= '0;
      tq_tail     <= '0;
      tq_cnt      <= '0;
      orphan_q    <= 1'b0;
      for (int j = 0; j < NUM_RD; j++) begin
        outst[j]   <= '0;
        occ[j]     <= '0;
        rb_head[j] <= '0;
        rb_tail[j] <= '0;
      end
    end else begin
      if (load) begin
        cmd_vld_p0  <= found;
        cmd_rd_p0   <= nxt_rd;
        cmd_ch_p0   <= nxt_ch;
        cmd_addr_p0 <= nxt_addr;
        cmd_data_p0 <= nxt_data;
        cmd_mask_p0 <= nxt_mask;
        if (found) rr_ptr <= (int'(win) == NREQ - 1) ? '0 : win + PTR_W'(1);
      end
      if (issue) tq_tail <= (tq_tail == TQ_W'(MAX_OUTST - 1)) ? '0 : tq_tail + TQ_W'(1);
      if (ret_ok) tq_head <= (tq_head == TQ_W'(MAX_OUTST - 1)) ? '0 : tq_head + TQ_W'(1);
      case ({issue, ret_ok})
        2'b10:   tq_cnt <= tq_cnt + TC_W'(1);
        2'b01:   tq_cnt <= tq_cnt - TC_W'(1);
        default: tq_cnt <= tq_cnt;
      endcase
      if (sram_data_out_valid && tq_cnt == '0) orphan_q <= 1'b1;
      for (int j = 0; j < NUM_RD; j++) begin
        case ({issue && int'(cmd_ch_p0) == j, rb_push[j]})
          2'b10:   outst[j] <= outst[j] + RC_W'(1);
          2'b01:   outst[j] <= outst[j] - RC_W'(1);
          default: outst[j] <= outst[j];
        endcase
        case ({rb_push[j], rb_pop[j]})
          2'b10:   occ[j] <= occ[j] + RC_W'(1);
          2'b01:   occ[j] <= occ[j] - RC_W'(1);
          default: occ[j] <= occ[j];
        endcase
        if (rb_push[j])
          rb_tail[j] <= (rb_tail[j] == RB_W'(RESP_DEPTH - 1)) ? '0 : rb_tail[j] + RB_W'(1);
        if (rb_pop[j])
          rb_head[j] <= (rb_head[j] == RB_W'(RESP_DEPTH - 1)) ? '0 : rb_head[j] + RB_W'(1);
      end
    end
  end

  // Stage p0 storage: tag and response memories carry data only
  always_ff @(posedge sram_clock) begin
    if (issue) tq_mem[tq_tail] <= cmd_ch_p0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (rb_push[j]) rb_mem[j][rb_tail[j]] <= sram_data_out;
    end
  end

  assign sram_addr_valid = cmd_vld_p0;
  assign sram_addr       = cmd_addr_p0;
  assign sram_data_in    = cmd_data_p0;
  assign sram_write_mask = cmd_mask_p0;
  assign orphan_err      = orphan_q;

endmodule
